// File: rtl/vmul_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vmul_wb_buffer
// Description : In-order write-back queue between the vector multiplier final
//               stage and the register-file write port, with RAW hazard flags.
// Revision    : 1.0 - initial release
// ============================================================================
module vmul_wb_buffer #(
    parameter int NUMLANES = 16,
    parameter int WIDTH    = 32,
    parameter int REGIDW   = 4,
    parameter int DEPTH    = 2,
    parameter int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW       = PW + 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [REGIDW-1:0]         in_dst,
    input  logic [NUMLANES-1:0]       in_mask,
    input  logic [NUMLANES*WIDTH-1:0] in_result,
    output logic                      stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REGIDW-1:0]         out_dst,
    output logic [NUMLANES-1:0]       out_mask,
    output logic [NUMLANES*WIDTH-1:0] out_data,
    input  logic [REGIDW-1:0]         rd_reg0,
    input  logic [REGIDW-1:0]         rd_reg1,
    output logic [1:0]                hazard,
    output logic [CW-1:0]             count,
    output logic                      overflow
);

    localparam logic [CW-1:0] c_full    = CW'(DEPTH);
    localparam logic [PW-1:0] c_ptr_one = PW'(1);
    localparam logic [PW-1:0] c_ptr_max = PW'(DEPTH - 1);

    logic [REGIDW-1:0]         r_dst  [DEPTH];
    logic [NUMLANES-1:0]       r_mask [DEPTH];
    logic [NUMLANES*WIDTH-1:0] r_data [DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_valid_req;
    logic w_push;
    logic w_pop;
    logic w_out_valid;

    logic [DEPTH-1:0] w_hit0;
    logic [DEPTH-1:0] w_hit1;

    // Full and stall depend only on registered state so the multiplier enables
    // never see a combinational path from the register-file handshake.
    assign w_full      = (r_count == c_full);
    assign w_out_valid = (r_count != '0);
    assign w_valid_req = in_valid && (|in_mask);
    assign w_push      = w_valid_req && !w_full;
    assign w_pop       = w_out_valid && out_ready;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_ptr_max) ? '0 : p + c_ptr_one;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_valid_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage is never reset; the head outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (resetn && w_push) begin
            r_dst[r_wr_ptr]  <= in_dst;
            r_mask[r_wr_ptr] <= in_mask;
            r_data[r_wr_ptr] <= in_result;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            logic [PW-1:0] w_offset;
            logic          w_occupied;

            // Distance from the head decides whether slot gi holds a live entry.
            assign w_offset    = PW'(gi) - r_rd_ptr;
            assign w_occupied  = ({1'b0, w_offset} < r_count);
            assign w_hit0[gi]  = w_occupied && (r_dst[gi] == rd_reg0);
            assign w_hit1[gi]  = w_occupied && (r_dst[gi] == rd_reg1);
        end
    endgenerate

    always_comb begin
        out_dst  = '0;
        out_mask = '0;
        out_data = '0;
        if (w_out_valid) begin
            out_dst  = r_dst[r_rd_ptr];
            out_mask = r_mask[r_rd_ptr];
            out_data = r_data[r_rd_ptr];
        end
    end

    assign hazard    = {|w_hit1, |w_hit0};
    assign stall     = w_full;
    assign out_valid = w_out_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vmul_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmul_wb_buffer
// Description : Directed self-checking bench for vmul_wb_buffer (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmul_wb_buffer;

    localparam int NUMLANES = 16;
    localparam int WIDTH    = 32;
    localparam int REGIDW   = 4;
    localparam int DEPTH    = 2;
    localparam int CW       = 2;
    localparam int DW       = NUMLANES * WIDTH;

    logic                clk = 1'b0;
    logic                resetn;
    logic                in_valid;
    logic [REGIDW-1:0]   in_dst;
    logic [NUMLANES-1:0] in_mask;
    logic [DW-1:0]       in_result;
    logic                stall;
    logic                out_valid;
    logic                out_ready;
    logic [REGIDW-1:0]   out_dst;
    logic [NUMLANES-1:0] out_mask;
    logic [DW-1:0]       out_data;
    logic [REGIDW-1:0]   rd_reg0;
    logic [REGIDW-1:0]   rd_reg1;
    logic [1:0]          hazard;
    logic [CW-1:0]       count;
    logic                overflow;

    int n_total = 0;
    int n_bad   = 0;

    vmul_wb_buffer #(
        .NUMLANES (NUMLANES),
        .WIDTH    (WIDTH),
        .REGIDW   (REGIDW),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_dst    (in_dst),
        .in_mask   (in_mask),
        .in_result (in_result),
        .stall     (stall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dst   (out_dst),
        .out_mask  (out_mask),
        .out_data  (out_data),
        .rd_reg0   (rd_reg0),
        .rd_reg1   (rd_reg1),
        .hazard    (hazard),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int dst);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < NUMLANES; i++) begin
            d[WIDTH*i +: WIDTH] = (32'(dst) * 32'h0101_0101) ^ (32'(i) << 20) ^ 32'h0000_A5C3;
        end
        return d;
    endfunction

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int dst, input logic [NUMLANES-1:0] m);
        in_valid  = v;
        in_dst    = REGIDW'(dst);
        in_mask   = m;
        in_result = mkdata(dst);
    endtask

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b0;
        rd_reg0   = '0;
        rd_reg1   = '0;
        drive(1'b0, 0, '0);
        step();
        step();
        chk("rst_count",    DW'(count),     DW'(0));
        chk("rst_valid",    DW'(out_valid), DW'(0));
        chk("rst_stall",    DW'(stall),     DW'(0));
        chk("rst_overflow", DW'(overflow),  DW'(0));
        chk("rst_hazard",   DW'(hazard),    DW'(0));
        chk("rst_out_data", out_data,       DW'(0));
        resetn = 1'b1;
        step();

        // Single entry pushed and drained
        out_ready = 1'b1;
        drive(1'b1, 5, 16'hFFFF);
        step();
        drive(1'b0, 0, '0);
        chk("single_valid", DW'(out_valid), DW'(1));
        chk("single_dst",   DW'(out_dst),   DW'(5));
        chk("single_mask",  DW'(out_mask),  DW'(16'hFFFF));
        chk("single_data",  out_data,       mkdata(5));
        chk("single_count", DW'(count),     DW'(1));
        step();
        chk("single_drain_count", DW'(count),     DW'(0));
        chk("single_drain_valid", DW'(out_valid), DW'(0));
        chk("single_drain_dst",   DW'(out_dst),   DW'(0));

        // All-zero mask is dropped silently
        drive(1'b1, 6, '0);
        step();
        drive(1'b0, 0, '0);
        chk("zmask_count",    DW'(count),    DW'(0));
        chk("zmask_overflow", DW'(overflow), DW'(0));

        // Fill to DEPTH, third push overflows
        out_ready = 1'b0;
        drive(1'b1, 1, 16'h0001);
        step();
        chk("fill1_count", DW'(count), DW'(1));
        chk("fill1_stall", DW'(stall), DW'(0));
        drive(1'b1, 2, 16'h0002);
        step();
        chk("fill2_count",    DW'(count),    DW'(2));
        chk("fill2_stall",    DW'(stall),    DW'(1));
        chk("fill2_overflow", DW'(overflow), DW'(0));
        drive(1'b1, 3, 16'h0004);
        step();
        drive(1'b0, 0, '0);
        chk("fill3_count",    DW'(count),    DW'(2));
        chk("fill3_overflow", DW'(overflow), DW'(1));
        chk("fill3_stall",    DW'(stall),    DW'(1));
        chk("fill3_head",     DW'(out_dst),  DW'(1));
        step();
        chk("hold_head", DW'(out_dst),  DW'(1));
        chk("hold_mask", DW'(out_mask), DW'(16'h0001));
        out_ready = 1'b1;
        step();
        chk("pop1_head",  DW'(out_dst),  DW'(2));
        chk("pop1_data",  out_data,      mkdata(2));
        chk("pop1_count", DW'(count),    DW'(1));
        chk("pop1_stall", DW'(stall),    DW'(0));
        step();
        chk("pop2_count",    DW'(count),    DW'(0));
        chk("overflow_sticky", DW'(overflow), DW'(1));

        // Hazard held through pop cycle, cleared after
        out_ready = 1'b0;
        rd_reg0   = 4'd7;
        rd_reg1   = 4'd3;
        chk("haz_empty", DW'(hazard), DW'(0));
        drive(1'b1, 7, 16'h00F0);
        step();
        drive(1'b0, 0, '0);
        chk("haz_queued", DW'(hazard), DW'(2'b01));
        out_ready = 1'b1;
        chk("haz_popcycle", DW'(hazard), DW'(2'b01));
        step();
        chk("haz_after_pop", DW'(hazard), DW'(2'b00));

        // Simultaneous push and pop at count 1
        out_ready = 1'b0;
        drive(1'b1, 9, 16'h0F00);
        step();
        chk("pp_pre_count", DW'(count),   DW'(1));
        chk("pp_pre_head",  DW'(out_dst), DW'(9));
        out_ready = 1'b1;
        drive(1'b1, 10, 16'hF000);
        step();
        drive(1'b0, 0, '0);
        chk("pp_count", DW'(count),   DW'(1));
        chk("pp_head",  DW'(out_dst), DW'(10));
        chk("pp_data",  out_data,     mkdata(10));
        step();
        chk("pp_drain", DW'(count), DW'(0));

        // Reset while full with overflow set
        out_ready = 1'b0;
        drive(1'b1, 3, 16'h1111);
        step();
        drive(1'b1, 7, 16'h2222);
        step();
        drive(1'b1, 8, 16'h4444);
        step();
        chk("rfull_count",    DW'(count),    DW'(2));
        chk("rfull_overflow", DW'(overflow), DW'(1));
        chk("rfull_hazard",   DW'(hazard),   DW'(2'b11));
        resetn = 1'b0;
        step();
        chk("rreset_count",    DW'(count),     DW'(0));
        chk("rreset_stall",    DW'(stall),     DW'(0));
        chk("rreset_overflow", DW'(overflow),  DW'(0));
        chk("rreset_valid",    DW'(out_valid), DW'(0));
        chk("rreset_hazard",   DW'(hazard),    DW'(0));
        chk("rreset_dst",      DW'(out_dst),   DW'(0));
        step();
        chk("rreset_ignore_in", DW'(count), DW'(0));
        drive(1'b0, 0, '0);
        resetn = 1'b1;
        step();
        chk("post_reset_count", DW'(count), DW'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
